// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Digit geometry and the reverse double-dabble correction values live here.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_MAX_DIGIT  = 9;
    localparam int BCD_ADJ_THRESH = 8;
    localparam int BCD_ADJ_VAL    = 3;

    function automatic logic digit_ok(
        input logic [BCD_DIGIT_W-1:0] digit
    );
        return digit <= BCD_DIGIT_W'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit correction step of reverse double-dabble.
// A digit that picked up a shifted-in high bit (>= 8) is pulled back by 3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    logic over;

    always_comb begin
        over = digit >= BCD_DIGIT_W'(BCD_ADJ_THRESH);
        if (over) begin
            adjusted = digit - BCD_DIGIT_W'(BCD_ADJ_VAL);
        end else begin
            adjusted = digit;
        end
    end

endmodule

// File: rtl/bcd_binary_seq.sv
// Sequential BCD-to-binary converter, one result bit per cycle.
// Valid/ready on both sides; malformed BCD short-circuits to DONE with err.
module bcd_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [BIN_W-1:0]              bin_out,
    output logic                          err,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    state_t state;
    state_t state_nx;

    logic [BCD_W-1:0]  bcd_reg;
    logic [BIN_W-1:0]  bin_reg;
    logic [CNT_W-1:0]  cnt;
    logic              err_reg;

    logic              accept;
    logic              in_ok;
    logic              last_step;
    logic [WORK_W-1:0] shifted;
    logic [BCD_W-1:0]  bcd_shifted;
    logic [BCD_W-1:0]  bcd_adj;

    assign accept    = in_valid && in_ready;
    assign last_step = cnt == CNT_W'(1);

    always_comb begin
        in_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!digit_ok(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                in_ok = 1'b0;
            end
        end
    end

    // Shift first, then correct every digit of the shifted BCD half.
    assign shifted     = {bcd_reg, bin_reg} >> 1;
    assign bcd_shifted = shifted[WORK_W-1:BIN_W];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit   (bcd_shifted[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted(bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = in_ok ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        bin_out   = bin_reg;
        err       = err_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            err_reg <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && in_ok) begin
                        bcd_reg <= bcd_in;
                        bin_reg <= '0;
                        cnt     <= CNT_W'(BIN_W);
                        err_reg <= 1'b0;
                    end else if (accept) begin
                        bcd_reg <= '0;
                        bin_reg <= '0;
                        cnt     <= '0;
                        err_reg <= 1'b1;
                    end
                end
                SHIFT: begin
                    bcd_reg <= bcd_adj;
                    bin_reg <= shifted[BIN_W-1:0];
                    cnt     <= cnt - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_binary_seq.sv
// Scoreboard bench for bcd_binary_seq: random and directed BCD values
// checked against a decimal reference model.
module tb_bcd_binary_seq;

    logic        clk;
    logic        rst_n;
    logic [11:0] bcd_in;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  bin_out;
    logic        err;
    logic        out_valid;
    logic        out_ready;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_accept = 0;
    bit rand_ready = 0;

    logic [10:0] exp_q[$];

    bcd_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bcd_in   (bcd_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bin_out  (bin_out),
        .err      (err),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal value of the nibbles, or err with zero result.
    function automatic logic [10:0] model(input logic [11:0] b);
        int val = 0;
        bit bad = 0;
        for (int i = 2; i >= 0; i--) begin
            int d = int'(b[i*4 +: 4]);
            if (d > 9) bad = 1;
            val = val * 10 + d;
        end
        if (bad) return {1'b1, 10'd0};
        return {1'b0, 10'(val)};
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic send(input logic [11:0] v, input bit hold);
        int n = 0;
        bcd_in   = v;
        in_valid = 1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                in_valid = 0;
                return;
            end
        end
        last_accept = cyc;
        exp_q.push_back(model(v));
        @(posedge clk);
        #1;
        if (!hold) in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        #1;
    endtask

    // Monitor: pops the scoreboard on each output handshake.
    logic [9:0] held_bin;
    logic       held_err;
    bit         held = 0;

    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                chk("in_ready_in_done", in_ready, 0);
                if (held) begin
                    chk("hold_bin", bin_out, held_bin);
                    chk("hold_err", err, held_err);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bin_out", bin_out, e[9:0]);
                    chk("err", err, e[10]);
                    if (!err) chk("bcd_residue", dut.bcd_reg, 0);
                end
            end
            held     = out_valid && !out_ready && rst_n;
            held_bin = bin_out;
            held_err = err;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int n;
        int acc0;
        logic [11:0] r;

        rst_n     = 0;
        bcd_in    = '0;
        in_valid  = 0;
        out_ready = 1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_bin", bin_out, 0);
        chk("rst_cnt", dut.cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;

        // 999: latency of BIN_W cycles after the accepting edge
        send(12'h999, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency_999", n, 10);
        drain();

        // 000 then 255 back to back, in_valid held
        send(12'h000, 1);
        acc0 = last_accept;
        send(12'h255, 0);
        chk("throughput", last_accept - acc0, 12);
        drain();

        // invalid digit, then a good value
        send(12'h1A3, 0);
        drain();
        send(12'h042, 0);
        drain();

        // stall the consumer for 20 cycles
        out_ready = 0;
        send(12'h500, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_bin", bin_out, 10'd500);
            chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        drain();

        // reset mid-conversion
        send(12'h876, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_err", err, 0);
        chk("abort_bin", bin_out, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1;
        send(12'h123, 0);
        drain();

        // exhaustive sweep with random gaps and consumer stalls
        rand_ready = 1;
        for (int v = 0; v < 1000; v++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(to_bcd(v), 0);
        end
        for (int i = 0; i < 40; i++) begin
            r = 12'($urandom);
            send(r, 0);
        end
        rand_ready = 0;
        @(posedge clk);
        #1;
        out_ready = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
